// File: rtl/dr_pkg.sv
// Dual-rail codeword constants, FSM state types and per-bit rail helpers
// shared by the memory bank and later dual-rail stages.
package dr_pkg;

    localparam int RAIL_NUM = 2;

    localparam logic [RAIL_NUM-1:0] DR_ONE  = 2'b10;
    localparam logic [RAIL_NUM-1:0] DR_ZERO = 2'b01;
    localparam logic [RAIL_NUM-1:0] DR_NULL = 2'b00;
    localparam logic [RAIL_NUM-1:0] DR_ILL  = 2'b11;

    typedef enum logic {
        W_IDLE,
        W_ACK
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DATA,
        R_RTZ
    } rd_state_e;

    function automatic logic [RAIL_NUM-1:0] dr_encode(input logic b);
        return b ? DR_ONE : DR_ZERO;
    endfunction

    function automatic logic dr_decode(input logic [RAIL_NUM-1:0] r);
        return r == DR_ONE;
    endfunction

    function automatic logic dr_complete(input logic [RAIL_NUM-1:0] r);
        return (r == DR_ONE) || (r == DR_ZERO);
    endfunction

    function automatic logic dr_is_null(input logic [RAIL_NUM-1:0] r);
        return r == DR_NULL;
    endfunction

    function automatic logic dr_has_illegal(input logic [RAIL_NUM-1:0] r);
        return r == DR_ILL;
    endfunction

endpackage

// File: rtl/dr_word_check.sv
// Combinational whole-word complete / spacer / illegal detection
// for a WIDTH-bit dual-rail word.
module dr_word_check
    import dr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] data,
    output logic               complete,
    output logic               is_null,
    output logic               illegal
);

    always_comb begin
        complete = 1'b1;
        is_null  = 1'b1;
        illegal  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            complete &= dr_complete(data[2*i +: 2]);
            is_null  &= dr_is_null(data[2*i +: 2]);
            illegal  |= dr_has_illegal(data[2*i +: 2]);
        end
    end

endmodule

// File: rtl/dr_mem_bank.sv
// Dual-rail register-file bank with four-phase write and read links.
// Define DR_MEM_BANK_ERR_CNT_EN to add the saturating err_cnt output.
module dr_mem_bank
    import dr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0,
    localparam int              AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [AW-1:0]      wr_addr,
    input  logic [2*WIDTH-1:0] wr_data,
    output logic               wr_ack,
    input  logic [AW-1:0]      rd_addr,
    input  logic               rd_req,
    output logic [2*WIDTH-1:0] rd_data,
    output logic               rd_ack,
    output logic               err
`ifdef DR_MEM_BANK_ERR_CNT_EN
    ,
    output logic [7:0]         err_cnt
`endif
);

    logic [WIDTH-1:0]   mem [DEPTH];
    wr_state_e          wr_st;
    rd_state_e          rd_st;
    logic               wr_complete;
    logic               wr_null;
    logic               wr_illegal;
    logic               wr_in_range;
    logic               rd_in_range;
    logic [WIDTH-1:0]   wr_bin;
    logic [WIDTH-1:0]   rd_bin;
    logic [2*WIDTH-1:0] rd_enc;

    dr_word_check #(
        .WIDTH(WIDTH)
    ) u_wr_check (
        .data    (wr_data),
        .complete(wr_complete),
        .is_null (wr_null),
        .illegal (wr_illegal)
    );

    assign wr_in_range = {1'b0, wr_addr} < (AW+1)'(DEPTH);
    assign rd_in_range = {1'b0, rd_addr} < (AW+1)'(DEPTH);

    // Storage is binary; rails are decoded on entry and re-encoded on exit.
    always_comb begin
        rd_bin = rd_in_range ? mem[rd_addr] : '0;
        for (int i = 0; i < WIDTH; i++) begin
            wr_bin[i]          = dr_decode(wr_data[2*i +: 2]);
            rd_enc[2*i +: 2]   = dr_encode(rd_bin[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_st  <= W_IDLE;
            wr_ack <= 1'b0;
            err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT;
            end
        end else begin
            if (wr_illegal) begin
                err <= 1'b1;
            end
            unique case (wr_st)
                W_IDLE: begin
                    if (wr_complete && !wr_illegal) begin
                        if (wr_in_range) begin
                            mem[wr_addr] <= wr_bin;
                        end
                        wr_st  <= W_ACK;
                        wr_ack <= 1'b1;
                    end
                end
                W_ACK: begin
                    if (wr_null) begin
                        wr_st  <= W_IDLE;
                        wr_ack <= 1'b0;
                    end
                end
            endcase
        end
    end

    // The word is captured at launch, so a same-edge write is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_st   <= R_IDLE;
            rd_ack  <= 1'b0;
            rd_data <= '0;
        end else begin
            unique case (rd_st)
                R_IDLE: begin
                    if (rd_req) begin
                        rd_st   <= R_DATA;
                        rd_ack  <= 1'b1;
                        rd_data <= rd_enc;
                    end
                end
                R_DATA: begin
                    if (!rd_req) begin
                        rd_st   <= R_RTZ;
                        rd_ack  <= 1'b0;
                        rd_data <= '0;
                    end
                end
                R_RTZ: begin
                    rd_st <= R_IDLE;
                end
                default: begin
                    rd_st   <= R_IDLE;
                    rd_ack  <= 1'b0;
                    rd_data <= '0;
                end
            endcase
        end
    end

`ifdef DR_MEM_BANK_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (wr_illegal && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
